tlb_op_ctrl: RTL and testbench

TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

---
 rtl/tlb_op_ctrl_if.sv | 48 ++++
 rtl/tlb_op_ctrl.sv | 152 +++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// Bundle between the pipeline/CP0 side (master) and the TLB op controller (slave).
interface tlb_op_ctrl_if;
    // Pipeline handshake
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic        busy;
    logic        done;
    // MMU strobes
    logic        tlbp;
    logic        tlbr;
    logic        tlbwi;
    logic        tlbwr;
    // MMU results
    logic [31:0] mmu_index;
    logic [31:0] mmu_pagemask;
    logic [31:0] mmu_entryhi;
    logic [31:0] mmu_entrylo0;
    logic [31:0] mmu_entrylo1;
    // CP0 Wired write and Random read
    logic        wired_we;
    logic [31:0] wired_wdata;
    logic [31:0] random_out;
    // CP0 write-back
    logic        cp0_index_we;
    logic [31:0] cp0_index_wdata;
    logic        cp0_entry_we;
    logic [31:0] cp0_pagemask_wdata;
    logic [31:0] cp0_entryhi_wdata;
    logic [31:0] cp0_entrylo0_wdata;
    logic [31:0] cp0_entrylo1_wdata;

    modport master (
        output op_valid, op_code, mmu_index, mmu_pagemask, mmu_entryhi, mmu_entrylo0,
               mmu_entrylo1, wired_we, wired_wdata,
        input  op_ready, busy, done, tlbp, tlbr, tlbwi, tlbwr, random_out, cp0_index_we,
               cp0_index_wdata, cp0_entry_we, cp0_pagemask_wdata, cp0_entryhi_wdata,
               cp0_entrylo0_wdata, cp0_entrylo1_wdata
    );

    modport slave (
        input  op_valid, op_code, mmu_index, mmu_pagemask, mmu_entryhi, mmu_entrylo0,
               mmu_entrylo1, wired_we, wired_wdata,
        output op_ready, busy, done, tlbp, tlbr, tlbwi, tlbwr, random_out, cp0_index_we,
               cp0_index_wdata, cp0_entry_we, cp0_pagemask_wdata, cp0_entryhi_wdata,
               cp0_entrylo0_wdata, cp0_entrylo1_wdata
    );
endinterface

// File: rtl/tlb_op_ctrl.sv
// TLB instruction sequencer: IDLE -> ISSUE (MMU strobe) -> WB (CP0 write-back, done),
// plus the CP0 Wired/Random registers used for TLBWR slot selection.
module tlb_op_ctrl #(
    parameter int unsigned TLB_LINE  = 32,
    parameter int unsigned TLB_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    tlb_op_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWb} state_e;

    localparam logic [1:0] OpTlbp  = 2'b00;
    localparam logic [1:0] OpTlbr  = 2'b01;
    localparam logic [1:0] OpTlbwi = 2'b10;
    localparam logic [1:0] OpTlbwr = 2'b11;

    localparam logic [TLB_WIDTH-1:0] RandMax = TLB_WIDTH'(TLB_LINE - 1);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [31:0]          index_q, pagemask_q, entryhi_q, entrylo0_q, entrylo1_q;
    logic [TLB_WIDTH-1:0] wired_q, wired_d;
    logic [TLB_WIDTH-1:0] random_q, random_d;
    logic                 reload_pend_q, reload_pend_d;
    logic                 rand_freeze;
    logic                 unused_wired_hi;

    assign unused_wired_hi = ^bus.wired_wdata[31:TLB_WIDTH];

    // Sequencer and op register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            op_q    <= OpTlbp;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next state: accept only in IDLE, then one cycle each in ISSUE and WB
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        unique case (state_q)
            StIdle: begin
                if (bus.op_valid) begin
                    state_d = StIssue;
                    op_d    = bus.op_code;
                end
            end
            StIssue: state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Capture MMU results at the ISSUE-to-WB edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            index_q    <= '0;
            pagemask_q <= '0;
            entryhi_q  <= '0;
            entrylo0_q <= '0;
            entrylo1_q <= '0;
        end else if (state_q == StIssue) begin
            if (op_q == OpTlbp) begin
                index_q <= bus.mmu_index;
            end
            if (op_q == OpTlbr) begin
                pagemask_q <= bus.mmu_pagemask;
                entryhi_q  <= bus.mmu_entryhi;
                entrylo0_q <= bus.mmu_entrylo0;
                entrylo1_q <= bus.mmu_entrylo1;
            end
        end
    end

    // Wired/Random registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wired_q       <= '0;
            random_q      <= RandMax;
            reload_pend_q <= 1'b0;
        end else begin
            wired_q       <= wired_d;
            random_q      <= random_d;
            reload_pend_q <= reload_pend_d;
        end
    end

    // Random must not move while the MMU consumes it for TLBWR; a Wired write seen
    // during that cycle defers its Random reload to the next unfrozen edge.
    assign rand_freeze = (state_q == StIssue) && (op_q == OpTlbwr);

    // Random next value: free-running decrement with wrap at or below Wired
    always_comb begin
        wired_d       = wired_q;
        random_d      = random_q;
        reload_pend_d = reload_pend_q;
        if (bus.wired_we) begin
            wired_d = bus.wired_wdata[TLB_WIDTH-1:0];
        end
        if (rand_freeze) begin
            if (bus.wired_we) begin
                reload_pend_d = 1'b1;
            end
        end else if (bus.wired_we || reload_pend_q) begin
            random_d      = RandMax;
            reload_pend_d = 1'b0;
        end else if (random_q <= wired_q) begin
            random_d = RandMax;
        end else begin
            random_d = random_q - TLB_WIDTH'(1);
        end
    end

    // MMU strobes: only in ISSUE, one-hot on the latched op
    always_comb begin
        bus.tlbp  = 1'b0;
        bus.tlbr  = 1'b0;
        bus.tlbwi = 1'b0;
        bus.tlbwr = 1'b0;
        if (state_q == StIssue) begin
            unique case (op_q)
                OpTlbp:  bus.tlbp  = 1'b1;
                OpTlbr:  bus.tlbr  = 1'b1;
                OpTlbwi: bus.tlbwi = 1'b1;
                OpTlbwr: bus.tlbwr = 1'b1;
                default: ;
            endcase
        end
    end

    // Handshake and write-back outputs; op_ready is held low while reset is asserted
    always_comb begin
        bus.op_ready           = rst && (state_q == StIdle);
        bus.busy               = (state_q != StIdle);
        bus.done               = (state_q == StWb);
        bus.cp0_index_we       = (state_q == StWb) && (op_q == OpTlbp);
        bus.cp0_entry_we       = (state_q == StWb) && (op_q == OpTlbr);
        bus.cp0_index_wdata    = index_q;
        bus.cp0_pagemask_wdata = pagemask_q;
        bus.cp0_entryhi_wdata  = entryhi_q;
        bus.cp0_entrylo0_wdata = entrylo0_q;
        bus.cp0_entrylo1_wdata = entrylo1_q;
        bus.random_out         = 32'(random_q);
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Scenario bench for tlb_op_ctrl: scoreboard of expected write-backs, per-feature tasks.
module tb_tlb_op_ctrl;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tlb_op_ctrl_if bus ();

    tlb_op_ctrl #(.TLB_LINE(32), .TLB_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        idx_we;
        logic        ent_we;
        logic [31:0] idx;
        logic [31:0] pm;
        logic [31:0] hi;
        logic [31:0] lo0;
        logic [31:0] lo1;
    } exp_t;

    exp_t sb[$];

    // One op through the controller; expected write-back is queued at drive time
    task automatic run_op(input logic [1:0] op, input logic [31:0] idx, input logic [31:0] pm,
                          input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        exp_t       e;
        exp_t       g;
        int         lat;
        logic [3:0] strb;
        logic [3:0] exp_strb;
        @(negedge clk);
        bus.op_valid     = 1'b1;
        bus.op_code      = op;
        bus.mmu_index    = idx;
        bus.mmu_pagemask = pm;
        bus.mmu_entryhi  = hi;
        bus.mmu_entrylo0 = lo0;
        bus.mmu_entrylo1 = lo1;
        e.op = op; e.idx_we = (op == 2'b00); e.ent_we = (op == 2'b01);
        e.idx = idx; e.pm = pm; e.hi = hi; e.lo0 = lo0; e.lo1 = lo1;
        sb.push_back(e);
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++; $display("FAIL op_ready_idle: got %b want 1", bus.op_ready);
        end
        @(negedge clk);
        bus.op_valid = 1'b0;
        strb     = {bus.tlbwr, bus.tlbwi, bus.tlbr, bus.tlbp};
        exp_strb = 4'b0001 << op;
        checks++;
        if (strb !== exp_strb || bus.busy !== 1'b1 || bus.op_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_strobe op=%0d: strb=%b busy=%b rdy=%b want strb=%b busy=1 rdy=0",
                     op, strb, bus.busy, bus.op_ready, exp_strb);
        end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 2) begin
            errors++; $display("FAIL done_latency op=%0d: got %0d want 2", op, lat);
        end
        if (bus.done === 1'b1) begin
            g = sb.pop_front();
            checks++;
            if (bus.cp0_index_we !== g.idx_we || bus.cp0_entry_we !== g.ent_we) begin
                errors++;
                $display("FAIL wb_enables op=%0d: idx_we=%b ent_we=%b want %b %b",
                         g.op, bus.cp0_index_we, bus.cp0_entry_we, g.idx_we, g.ent_we);
            end
            // change MMU inputs so write-back must come from the holding registers
            bus.mmu_index = $urandom; bus.mmu_entryhi = $urandom;
            bus.mmu_pagemask = $urandom; bus.mmu_entrylo0 = $urandom; bus.mmu_entrylo1 = $urandom;
            #1;
            if (g.idx_we) begin
                checks++;
                if (bus.cp0_index_wdata !== g.idx) begin
                    errors++;
                    $display("FAIL index_wdata: got %h want %h", bus.cp0_index_wdata, g.idx);
                end
            end
            if (g.ent_we) begin
                checks++;
                if (bus.cp0_pagemask_wdata !== g.pm || bus.cp0_entryhi_wdata !== g.hi ||
                    bus.cp0_entrylo0_wdata !== g.lo0 || bus.cp0_entrylo1_wdata !== g.lo1) begin
                    errors++;
                    $display("FAIL entry_wdata: got %h %h %h %h want %h %h %h %h",
                             bus.cp0_pagemask_wdata, bus.cp0_entryhi_wdata,
                             bus.cp0_entrylo0_wdata, bus.cp0_entrylo1_wdata,
                             g.pm, g.hi, g.lo0, g.lo1);
                end
            end
        end else begin
            void'(sb.pop_front());
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.op_ready !== 1'b1 || bus.cp0_index_we !== 1'b0 ||
            bus.cp0_entry_we !== 1'b0) begin
            errors++;
            $display("FAIL after_wb: done=%b rdy=%b iwe=%b ewe=%b want 0 1 0 0",
                     bus.done, bus.op_ready, bus.cp0_index_we, bus.cp0_entry_we);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.op_valid = 1'b1; bus.op_code = 2'b01;
        bus.mmu_index = '0; bus.mmu_pagemask = '0; bus.mmu_entryhi = '0;
        bus.mmu_entrylo0 = '0; bus.mmu_entrylo1 = '0;
        bus.wired_we = 1'b0; bus.wired_wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.op_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            {bus.tlbp, bus.tlbr, bus.tlbwi, bus.tlbwr} !== 4'b0 ||
            bus.cp0_index_we !== 1'b0 || bus.cp0_entry_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy=%b busy=%b done=%b strb=%b iwe=%b ewe=%b want all 0",
                     bus.op_ready, bus.busy, bus.done, {bus.tlbp, bus.tlbr, bus.tlbwi, bus.tlbwr},
                     bus.cp0_index_we, bus.cp0_entry_we);
        end
        checks++;
        if (bus.cp0_index_wdata !== 32'h0 || bus.cp0_entryhi_wdata !== 32'h0 ||
            bus.cp0_pagemask_wdata !== 32'h0 || bus.cp0_entrylo0_wdata !== 32'h0 ||
            bus.cp0_entrylo1_wdata !== 32'h0 || bus.random_out !== 32'd31) begin
            errors++;
            $display("FAIL reset_data: idx=%h hi=%h random=%0d want 0 0 31",
                     bus.cp0_index_wdata, bus.cp0_entryhi_wdata, bus.random_out);
        end
        bus.op_valid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_tlbp();
        run_op(2'b00, 32'h0000_0007, 32'h1111_1111, 32'h2222_2222, 32'h3, 32'h4);
        run_op(2'b00, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_tlbr();
        run_op(2'b01, 32'h0000_0003, 32'h0001_e000, 32'h1234_5000, 32'h0000_1f17, 32'h0000_2f1f);
    endtask

    task automatic test_tlbwi();
        run_op(2'b10, 32'h0000_0009, 32'h5, 32'h6, 32'h7, 32'h8);
    endtask

    task automatic test_random_wrap();
        int exp_r;
        @(negedge clk);
        bus.wired_we = 1'b1; bus.wired_wdata = 32'hffff_ff04;
        @(negedge clk);
        bus.wired_we = 1'b0;
        for (int i = 0; i < 30; i++) begin
            exp_r = (i <= 27) ? 31 - i : 59 - i;
            checks++;
            if (bus.random_out !== 32'(exp_r)) begin
                errors++; $display("FAIL random_seq[%0d]: got %0d want %0d", i, bus.random_out, exp_r);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_tlbwr_freeze();
        int guard;
        guard = 0;
        while (bus.random_out !== 32'd11 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.random_out !== 32'd11) begin
            errors++; $display("FAIL random_reach11: got %0d want 11", bus.random_out);
        end
        bus.op_valid = 1'b1; bus.op_code = 2'b11;
        sb.push_back('{op: 2'b11, idx_we: 1'b0, ent_we: 1'b0, idx: '0, pm: '0, hi: '0,
                       lo0: '0, lo1: '0});
        @(negedge clk);
        bus.op_valid = 1'b0;
        checks++;
        if (bus.tlbwr !== 1'b1 || bus.random_out !== 32'd10) begin
            errors++;
            $display("FAIL tlbwr_issue: tlbwr=%b random=%0d want 1 10", bus.tlbwr, bus.random_out);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.random_out !== 32'd10 || bus.cp0_index_we !== 1'b0 ||
            bus.cp0_entry_we !== 1'b0) begin
            errors++;
            $display("FAIL tlbwr_wb: done=%b random=%0d iwe=%b ewe=%b want 1 10 0 0",
                     bus.done, bus.random_out, bus.cp0_index_we, bus.cp0_entry_we);
        end
        if (bus.done === 1'b1) void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (bus.random_out !== 32'd9) begin
            errors++; $display("FAIL tlbwr_after: random=%0d want 9", bus.random_out);
        end
    endtask

    task automatic test_wired_max();
        @(negedge clk);
        bus.wired_we = 1'b1; bus.wired_wdata = 32'd31;
        @(negedge clk);
        bus.wired_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.random_out !== 32'd31) begin
                errors++; $display("FAIL wired_max_hold[%0d]: got %0d want 31", i, bus.random_out);
            end
            @(negedge clk);
        end
        bus.wired_we = 1'b1; bus.wired_wdata = 32'd0;
        @(negedge clk);
        bus.wired_we = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pos[$];
        int p;
        pos.push_back(0); pos.push_back(3); pos.push_back(6);
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 2'b00; bus.mmu_index = 32'h5;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (bus.tlbp === 1'b1) begin
                checks++;
                if (pos.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: strobe at %0d want none", k);
                end else begin
                    p = pos.pop_front();
                    if (p != k) begin
                        errors++; $display("FAIL b2b_spacing: strobe at %0d want %0d", k, p);
                    end
                end
            end
        end
        bus.op_valid = 1'b0;
        checks++;
        if (pos.size() != 0) begin
            errors++; $display("FAIL b2b_missing: %0d strobes missing want 0", pos.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_midop();
        @(negedge clk);
        bus.op_valid = 1'b1; bus.op_code = 2'b01; bus.mmu_entryhi = 32'hdead_b000;
        @(negedge clk);
        bus.op_valid = 1'b0;
        checks++;
        if (bus.tlbr !== 1'b1) begin
            errors++; $display("FAIL midop_issue: tlbr=%b want 1", bus.tlbr);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.op_ready !== 1'b0 || bus.busy !== 1'b0 || bus.tlbr !== 1'b0 ||
            bus.random_out !== 32'd31) begin
            errors++;
            $display("FAIL midop_rst: rdy=%b busy=%b tlbr=%b random=%0d want 0 0 0 31",
                     bus.op_ready, bus.busy, bus.tlbr, bus.random_out);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.cp0_entry_we !== 1'b0 || bus.cp0_entryhi_wdata !== 32'h0) begin
                errors++;
                $display("FAIL midop_nowb: done=%b ewe=%b hi=%h want 0 0 0",
                         bus.done, bus.cp0_entry_we, bus.cp0_entryhi_wdata);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.op_ready !== 1'b1) begin
            errors++; $display("FAIL midop_release: op_ready=%b want 1", bus.op_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.cp0_entry_we !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: done=%b ewe=%b busy=%b want 0 0 0",
                     bus.done, bus.cp0_entry_we, bus.busy);
        end
    endtask

    initial begin
        test_reset();
        test_tlbp();
        test_tlbr();
        test_tlbwi();
        test_random_wrap();
        test_tlbwr_freeze();
        test_wired_max();
        test_back_to_back();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
